// File: rtl/map_tile_loader_if.sv
// Byte-stream ingress and map RAM write-port bundle for map_tile_loader.
// The master side is the stream source and RAM. The slave side is the loader.
interface map_tile_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        byte_in;
    logic              byte_valid_in;
    logic              byte_ready_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [3:0]        wr_data_out;
    logic              wr_en_out;

    modport master (
        output byte_in,
        output byte_valid_in,
        input  byte_ready_out,
        input  wr_addr_out,
        input  wr_data_out,
        input  wr_en_out
    );

    modport slave (
        input  byte_in,
        input  byte_valid_in,
        output byte_ready_out,
        output wr_addr_out,
        output wr_data_out,
        output wr_en_out
    );
endinterface

// File: rtl/map_tile_loader.sv
// Unpacks a framed byte stream (HEADER, id, payload, XOR checksum) into 4-bit tile writes.
// Optional MAP_TILE_LOADER_CLAMP_EN: nibbles above 11 are written as wall (4'd1).
//
// state      | meaning
// S_IDLE     | waiting for HEADER, other bytes dropped
// S_ID       | next byte is the map id
// S_LO       | next byte is payload, low nibble written now
// S_HI       | high nibble of held byte written, stream stalled
// S_CHECK    | next byte is the checksum
module map_tile_loader #(
    parameter int         WIDTH   = 160,
    parameter int         HEIGHT  = 90,
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1000000
) (
    input  logic             pixel_clk_in,
    input  logic             rst_in,
    map_tile_loader_if.slave bus,
    output logic [7:0]       map_id_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             error_out,
    output logic             map_valid_out
);

    localparam int TILES  = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(TILES);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TILES - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ID    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] tile_addr_q, tile_addr_d;
    logic [3:0]        hi_nib_q,    hi_nib_d;
    logic [7:0]        checksum_q,  checksum_d;
    logic [TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [3:0]        wr_data_q,   wr_data_d;
    logic [7:0]        map_id_q,    map_id_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              error_q,     error_d;
    logic              map_valid_q, map_valid_d;

    logic              byte_ready;
    logic              accept;
    logic              tmo_counting;
    logic [ADDR_W-1:0] hi_addr;

    function automatic logic [3:0] tile_code(input logic [3:0] nib);
`ifdef MAP_TILE_LOADER_CLAMP_EN
        return (nib > 4'd11) ? 4'd1 : nib;
`else
        return nib;
`endif
    endfunction

    assign byte_ready   = (state_q != S_HI);
    assign accept       = bus.byte_valid_in && byte_ready;
    assign tmo_counting = (state_q == S_ID) || (state_q == S_LO) || (state_q == S_CHECK);
    assign hi_addr      = tile_addr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        tile_addr_d = tile_addr_q;
        hi_nib_d    = hi_nib_q;
        checksum_d  = checksum_q;
        tmo_cnt_d   = tmo_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        map_id_d    = map_id_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        map_valid_d = map_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept && (bus.byte_in == HEADER)) begin
                    state_d     = S_ID;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    map_valid_d = 1'b0;
                    checksum_d  = 8'h00;
                    tile_addr_d = '0;
                end
            end
            S_ID: begin
                if (accept) begin
                    map_id_d = bus.byte_in;
                    state_d  = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = tile_addr_q;
                    wr_data_d  = tile_code(bus.byte_in[3:0]);
                    hi_nib_d   = bus.byte_in[7:4];
                    checksum_d = checksum_q ^ bus.byte_in;
                    state_d    = S_HI;
                end
            end
            S_HI: begin
                wr_en_d   = 1'b1;
                wr_addr_d = hi_addr;
                wr_data_d = tile_code(hi_nib_q);
                if (hi_addr == LAST_ADDR) begin
                    state_d = S_CHECK;
                end else begin
                    tile_addr_d = tile_addr_q + ADDR_W'(2);
                    state_d     = S_LO;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (bus.byte_in == checksum_q) begin
                        done_d      = 1'b1;
                        map_valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Down-counter reloads on every accepted byte; expiry aborts the frame.
        if (accept) begin
            tmo_cnt_d = TMO_LOAD;
        end else if (tmo_counting) begin
            if (tmo_cnt_q == '0) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                error_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            tile_addr_q <= '0;
            hi_nib_q    <= 4'h0;
            checksum_q  <= 8'h00;
            tmo_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 4'h0;
            map_id_q    <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            map_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_addr_q <= tile_addr_d;
            hi_nib_q    <= hi_nib_d;
            checksum_q  <= checksum_d;
            tmo_cnt_q   <= tmo_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            map_id_q    <= map_id_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            map_valid_q <= map_valid_d;
        end
    end

    assign bus.byte_ready_out = byte_ready;
    assign bus.wr_en_out      = wr_en_q;
    assign bus.wr_addr_out    = wr_addr_q;
    assign bus.wr_data_out    = wr_data_q;
    assign map_id_out         = map_id_q;
    assign busy_out           = busy_q;
    assign done_out           = done_q;
    assign error_out          = error_q;
    assign map_valid_out      = map_valid_q;

endmodule

// File: tb/tb_map_tile_loader.sv
// Directed, table-driven bench for map_tile_loader on a 4x2 map with a 16-cycle timeout.
module tb_map_tile_loader;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    map_tile_loader_if #(.ADDR_W(3)) bus ();

    logic [7:0] map_id;
    logic       busy, done, err, mvalid;

    map_tile_loader #(
        .WIDTH  (W),
        .HEIGHT (H),
        .HEADER (8'hA5),
        .TIMEOUT(TMO)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus),
        .map_id_out   (map_id),
        .busy_out     (busy),
        .done_out     (done),
        .error_out    (err),
        .map_valid_out(mvalid)
    );

    typedef struct {
        logic [7:0]  id;
        logic [31:0] payload;   // byte k at [8k+7:8k]
        logic [7:0]  cks;
        int          gap;
        logic [31:0] nib;       // expected write data for address i at [4i+3:4i]
        logic        good;
    } vec_t;

    vec_t vecs[5];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_total = 0;
    logic [2:0] log_addr[$];
    logic [3:0] log_data[$];
    int         log_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.wr_en_out) begin
            log_addr.push_back(bus.wr_addr_out);
            log_data.push_back(bus.wr_data_out);
            log_cyc.push_back(cyc);
            wr_total++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int k);
        bus.byte_valid_in = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    // Entered and left at a falling edge; valid stays high after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in       = b;
        bus.byte_valid_in = 1'b1;
        while (!bus.byte_ready_out) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL ready_wait: byte %0h not accepted within 40 cycles", b);
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        clear_log();
        send_byte(8'hA5);
        chk($sformatf("%s.hdr_busy", tag), busy, 1);
        chk($sformatf("%s.hdr_err_clr", tag), err, 0);
        chk($sformatf("%s.hdr_valid_clr", tag), mvalid, 0);
        idle(v.gap);
        send_byte(v.id);
        for (int k = 0; k < 4; k++) begin
            idle(v.gap);
            send_byte(v.payload[8*k +: 8]);
        end
        idle(v.gap);
        send_byte(v.cks);
        chk($sformatf("%s.done_now", tag), done, v.good);
        chk($sformatf("%s.busy_end", tag), busy, 0);
        idle(4);
        chk($sformatf("%s.map_id", tag), map_id, v.id);
        chk($sformatf("%s.done_cnt", tag), done_cnt, v.good ? 1 : 0);
        chk($sformatf("%s.error", tag), err, !v.good);
        chk($sformatf("%s.map_valid", tag), mvalid, v.good);
        chk($sformatf("%s.nwrites", tag), log_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_addr.size())
                chk($sformatf("%s.wr%0d", tag, i), {log_addr[i], log_data[i]},
                    {i[2:0], v.nib[4*i +: 4]});
        end
        if (v.gap == 0 && log_cyc.size() == 8)
            chk($sformatf("%s.contiguous", tag), log_cyc[7] - log_cyc[0], 7);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap;

        // XOR of 21,43,65,87 is 80
        vecs[0] = '{id: 8'h07, payload: 32'h87654321, cks: 8'h80, gap: 0, nib: 32'h87654321, good: 1'b1};
        vecs[1] = '{id: 8'h07, payload: 32'h87654321, cks: 8'h81, gap: 0, nib: 32'h87654321, good: 1'b0};
`ifdef MAP_TILE_LOADER_CLAMP_EN
        vecs[2] = '{id: 8'h3C, payload: 32'h12A500FC, cks: 8'h4B, gap: 0, nib: 32'h12A50011, good: 1'b1};
`else
        vecs[2] = '{id: 8'h3C, payload: 32'h12A500FC, cks: 8'h4B, gap: 0, nib: 32'h12A500FC, good: 1'b1};
`endif
        vecs[3] = '{id: 8'hFF, payload: 32'h76543210, cks: 8'h00, gap: 3, nib: 32'h76543210, good: 1'b1};
        vecs[4] = '{id: 8'h5A, payload: 32'h0BB00BB0, cks: 8'h5A, gap: 1, nib: 32'h0BB00BB0, good: 1'b0};

        rst               = 1'b1;
        bus.byte_in       = 8'h00;
        bus.byte_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ready", bus.byte_ready_out, 1);
        chk("rst.wr_en", bus.wr_en_out, 0);
        chk("rst.wr_addr", bus.wr_addr_out, 0);
        chk("rst.wr_data", bus.wr_data_out, 0);
        chk("rst.map_id", map_id, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.error", err, 0);
        chk("rst.map_valid", mvalid, 0);
        rst = 1'b0;
        @(negedge clk);

        clear_log();
        send_byte(8'h00);
        chk("junk0.busy", busy, 0);
        send_byte(8'hFF);
        chk("junk1.busy", busy, 0);
        send_byte(8'h5A);
        chk("junk2.busy", busy, 0);
        idle(3);
        chk("junk.no_writes", wr_total, 0);
        run_frame("after_junk", vecs[0]);

        for (int v = 0; v < 5; v++)
            run_frame($sformatf("vec%0d", v), vecs[v]);

        clear_log();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h21);
        idle(16);
        chk("tmo.err_before", err, 0);
        chk("tmo.busy_before", busy, 1);
        idle(1);
        chk("tmo.err", err, 1);
        chk("tmo.busy", busy, 0);
        chk("tmo.map_valid", mvalid, 0);
        chk("tmo.ready", bus.byte_ready_out, 1);
        run_frame("after_tmo", vecs[0]);

        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h21);
        send_byte(8'h43);
        send_byte(8'h65);
        bus.byte_valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        snap = wr_total;
        chk("midrst.wr_en", bus.wr_en_out, 0);
        idle(10);
        chk("midrst.no_writes", wr_total, snap);
        chk("midrst.map_valid", mvalid, 0);
        chk("midrst.ready", bus.byte_ready_out, 1);
        chk("midrst.busy", busy, 0);
        chk("midrst.wr_addr", bus.wr_addr_out, 0);
        run_frame("after_rst", vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
